// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared op and state encodings for the multiply/divide unit.
// Revision    : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_if
// Description : Start/done handshake and result bus of the multiply/divide unit.
// Revision    : 1.0
// ============================================================================
interface muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort,
        output busy, done, div_zero, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One combinational shift-add (multiply) or restoring (divide) step.
// Revision    : 1.0
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic               is_div_i,
    input  wire logic [2*WIDTH-1:0] acc_i,
    input  wire logic [WIDTH-1:0]   opnd_i,
    output logic      [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : {WIDTH{1'b0}})};
        trial = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff  = trial - {1'b0, opnd_i};
        if (is_div_i) begin
            if (diff[WIDTH]) begin
                acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Sequential signed/unsigned multiply and divide feeding HIGH/LOW.
// Revision    : 1.0
// ============================================================================
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input wire logic    clk,
    input wire logic    reset,
    muldiv_seq_if.slave bus
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_step;
    logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
    logic               is_div_q, qneg_q, rneg_q, dz_q, done_q, div_zero_q;
    logic               start_sgn, start_div;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = (op_is_div(bus.op) && (bus.b == '0)) ? S_FINISH : S_RUN;
                end
            end
            S_RUN: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FINISH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q != S_IDLE);
        bus.done     = done_q;
        bus.div_zero = div_zero_q;
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end

    // Magnitudes are iterated; signs are restored once the last step is done.
    always_comb begin
        start_sgn = op_is_signed(bus.op);
        start_div = op_is_div(bus.op);
        prod_fix  = qneg_q ? -acc_q : acc_q;
        if (is_div_q) begin
            res_lo = qneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            res_hi = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
            res_lo = prod_fix[WIDTH-1:0];
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        is_div_q <= start_div;
                        qneg_q   <= start_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_q   <= start_sgn & bus.a[WIDTH-1];
                        dz_q     <= start_div && (bus.b == '0);
                        cnt_q    <= CNT_W'(WIDTH);
                        if (start_div) begin
                            acc_q  <= {{WIDTH{1'b0}}, mag(bus.a, start_sgn)};
                            opnd_q <= mag(bus.b, start_sgn);
                        end else begin
                            acc_q  <= {{WIDTH{1'b0}}, mag(bus.b, start_sgn)};
                            opnd_q <= mag(bus.a, start_sgn);
                        end
                    end
                end
                S_RUN: begin
                    if (!bus.abort) begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_FINISH: begin
                    if (!bus.abort) begin
                        done_q <= 1'b1;
                        if (dz_q) begin
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq against an arithmetic model.
// Revision    : 1.0
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if #(.WIDTH(32)) bus32 ();
    muldiv_seq_if #(.WIDTH(8))  bus8  ();

    muldiv_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    muldiv_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] model_hilo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: {hi, lo} as the spec defines them, prev returned on b==0 divide.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb;
        int     qa, qb, q, r;
        case (op)
            OP_MULT: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                return sa * sb;
            end
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return prev;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qa = $signed(a);
                qb = $signed(b);
                q  = qa / qb;
                r  = qa % qb;
                return {r, q};
            end
            default: begin
                if (b == 0) return prev;
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic start32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.a     = a;
        bus32.b     = b;
        @(posedge clk); #1;
        bus32.start = 1'b0;
    endtask

    // Returns #1 after the edge that raised done, so a follow-up call starts in the done cycle.
    task automatic run32(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit abort_start, input int pulse_at);
        logic [63:0] exp;
        int          exp_lat, lat;
        logic        busy_ok, exp_dz;
        exp     = ref_model(op, a, b, model_hilo);
        exp_dz  = op[1] && (b == 0);
        exp_lat = exp_dz ? 1 : 33;
        if (abort_start) bus32.abort = 1'b1;
        start32(op, a, b);
        bus32.abort = 1'b0;
        if (pulse_at > 0) begin
            bus32.op = OP_DIVU;
            bus32.a  = 32'd1;
            bus32.b  = 32'd0;
        end
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus32.done && lat < 100) begin
            if (!bus32.busy) busy_ok = 1'b0;
            bus32.start = (pulse_at > 0 && lat == pulse_at);
            @(posedge clk); #1;
            lat++;
        end
        bus32.start = 1'b0;
        if (bus32.busy) busy_ok = 1'b0;
        chk({tag, "_lat"},  64'(lat), 64'(exp_lat));
        chk({tag, "_hilo"}, {bus32.hi, bus32.lo}, exp);
        chk({tag, "_dz"},   64'(bus32.div_zero), 64'(exp_dz));
        chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
        model_hilo = exp;
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.a     = a;
        bus8.b     = b;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        lat = 0;
        while (!bus8.done && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        logic        saw_done;
        logic [63:0] held;
        int          lat8;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        bus32.start = 0; bus32.op = 0; bus32.a = 0; bus32.b = 0; bus32.abort = 0;
        bus8.start  = 0; bus8.op  = 0; bus8.a  = 0; bus8.b  = 0; bus8.abort  = 0;

        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus32.busy), 64'd0);
        chk("rst_done", 64'({bus32.done, bus32.div_zero}), 64'd0);
        chk("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Signed multiply, then all-ones unsigned product chained into 3*5
        run32("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 0);
        chk("mult_neg_lit", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk); #1;
        run32("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
        chk("multu_max_lit", {bus32.hi, bus32.lo}, 64'hFFFF_FFFE_0000_0001);
        run32("b2b", OP_MULTU, 32'd3, 32'd5, 1'b0, 0);
        chk("b2b_lit", {bus32.hi, bus32.lo}, 64'd15);
        @(posedge clk); #1;

        run32("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        chk("div_neg_lit", {bus32.hi, bus32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run32("divu", OP_DIVU, 32'd100, 32'd7, 1'b0, 0);
        chk("divu_lit", {bus32.hi, bus32.lo}, {32'd2, 32'd14});
        run32("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        chk("div_ovf_lit", {bus32.hi, bus32.lo}, {32'd0, 32'h8000_0000});
        @(posedge clk); #1;

        // Divide by zero keeps the preloaded 2*3
        run32("pre", OP_MULTU, 32'd2, 32'd3, 1'b0, 0);
        @(posedge clk); #1;
        run32("dz", OP_DIVU, 32'd5, 32'd0, 1'b0, 0);
        chk("dz_lit", {bus32.hi, bus32.lo}, 64'd6);
        @(posedge clk); #1;
        chk("dz_pulse", 64'({bus32.done, bus32.div_zero}), 64'd0);

        // Abort on the 10th busy cycle
        start32(OP_MULT, 32'd123, 32'd456);
        repeat (9) begin @(posedge clk); #1; end
        bus32.abort = 1'b1;
        @(posedge clk); #1;
        bus32.abort = 1'b0;
        chk("abort_busy", 64'(bus32.busy), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus32.done) saw_done = 1'b1;
        end
        chk("abort_nodone", 64'(saw_done), 64'd0);
        chk("abort_hilo", {bus32.hi, bus32.lo}, model_hilo);

        // Abort with start in IDLE, and a stray start pulse mid-run
        run32("abort_idle", OP_MULTU, 32'd9, 32'd11, 1'b1, 0);
        @(posedge clk); #1;
        run32("start_busy", OP_MULT, 32'hFFFF_FF00, 32'h0000_1234, 1'b0, 5);
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run32($sformatf("rnd%0d", i), rop, ra, rb, 1'b0, 0);
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end

        // Asynchronous reset mid-run on the 8-bit unit
        run8(OP_MULTU, 8'h07, 8'h05, lat8);
        chk("w8_pre", {bus8.hi, bus8.lo}, 64'h0023);
        @(posedge clk); #1;
        bus8.start = 1'b1; bus8.op = OP_MULT; bus8.a = 8'h11; bus8.b = 8'h02;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        held = {bus32.hi, bus32.lo};
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(bus8.busy), 64'd0);
        chk("arst_done", 64'(bus8.done), 64'd0);
        chk("arst_hilo", {bus8.hi, bus8.lo}, 64'd0);
        chk("arst_hilo32", {bus32.hi, bus32.lo}, (held == 64'd0) ? 64'd0 : 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run8(OP_MULT, 8'hF0, 8'h03, lat8);
        chk("w8_lat", 64'(lat8), 64'd9);
        chk("w8_hilo", {bus8.hi, bus8.lo}, 64'hFFD0);
        chk("w8_dz", 64'(bus8.div_zero), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised sequential multiply/divide unit.
- Replaces the separate fixed-width mult and div blocks that feed the HIGH/LOW registers in the multicycle CPU datapath.
- Four operations: signed and unsigned multiply, signed and unsigned divide. One start/done handshake, a busy flag, divide-by-zero flagging and an abort input.
- The control unit starts an operation from the A/B register outputs and loads HIGH/LOW on done.

Parameters:
- WIDTH, 32, operand width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op  in  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
- a  in  WIDTH  multiplicand/dividend; sampled with start.
- b  in  WIDTH  multiplier/divisor; sampled with start.
- abort  in  1  cancel the operation in progress.
- busy  out  1  high while an operation is in progress.
- done  out  1  single-cycle pulse; hi/lo are valid in this cycle.
- div_zero  out  1  high with done when a divide had b==0.
- hi  out  WIDTH  multiply: upper product half; divide: remainder.
- lo  out  WIDTH  multiply: lower product half; divide: quotient.

Behaviour:
- Reset (reset=0, async): state=IDLE; busy, done, div_zero, hi, lo, counter and all internal registers = 0.
- States:
  - IDLE: start=1 latches op, a, b. Goes to RUN, or to FINISH if op is a divide and b==0.
  - RUN: one iteration per cycle for exactly WIDTH cycles, counter counting down WIDTH..1.
  - FINISH: one cycle, then IDLE.
- Multiply: radix-2 shift-add on operand magnitudes; 2*WIDTH-bit product. Signed ops negate the product in FINISH when sign(a)^sign(b).
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a). Result truncates toward zero.
  - Signed most-negative / -1: lo = most-negative value (wraps), hi=0. No flag.
- Latency: start accepted at edge k.
  - busy=1 from k+1 through k+WIDTH+1.
  - done=1 and hi/lo valid in the cycle after edge k+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
  - busy falls together with done.
- Divide by zero: done one cycle after acceptance with div_zero=1; hi and lo hold their previous values.
- hi/lo hold the last result until the next done. They are never updated mid-operation.
- done and div_zero are 0 in every cycle except the FINISH cycle.
- start while busy: ignored, no queuing. Back-to-back ops are allowed: start in the same cycle as done is accepted.
- abort=1 in RUN or FINISH: next state IDLE, busy=0. No done; hi/lo unchanged. abort in IDLE has no effect.
- abort and start in the same cycle in IDLE: start wins.
- Reset mid-operation: immediate return to the reset values above; no done pulse.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encoding localparams OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state encoding S_IDLE, S_RUN, S_FINISH (2-bit).
- The control unit imports the same op constants.
- One natural sub-module: muldiv_step. It is combinational and performs one iteration: the add/shift for multiply or the trial subtract/shift for divide. The FSM, counter and sign fix-up stay in muldiv_seq.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFD (-3), b=7 -> done exactly 33 cycles after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; immediately start MULTU 3*5 in the done cycle -> accepted, lo=15, hi=0.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Preload hi/lo via MULTU 2*3. Then DIVU a=5, b=0 -> done one cycle after start with div_zero=1; hi=0, lo=6 unchanged.
5. Start MULT, assert abort on the 10th busy cycle -> busy=0 next cycle, no done for 40 cycles, hi/lo unchanged. Pulse start while busy in a separate run -> no effect on result or timing.
6. Drive reset low asynchronously mid-RUN -> busy, hi, lo, done go to 0 without a clock edge. Release, run WIDTH=8 MULT 0xF0*0x03 (-16*3) -> done after 9 cycles, hi=0xFF, lo=0xD0.
